fifo_axis_reader: RTL and testbench

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

---
 rtl/pcie_phy_pkg.sv | 14 +
 rtl/fifo_reader_buf.sv | 52 +++++
 rtl/fifo_axis_reader.sv | 81 ++++++++
 tb/tb_fifo_axis_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared constants and types for the FIFO-to-AXI-Stream reader: local buffer
// depth, occupancy/pointer types and the circular pointer increment.
package pcie_phy_pkg;

  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] occ_t;
  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Three-entry circular skid buffer: tail write, head pop and occupancy count.
// Entries are cleared on reset so the head reads as zero until data arrives.
module fifo_reader_buf
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output occ_t                  occ_o
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  ptr_t                  r_wr_ptr;
  ptr_t                  r_rd_ptr;
  occ_t                  r_occ;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_i) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  // The issue logic upstream guarantees no write when full and no pop when empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (wr_i) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (pop_i) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_occ <= r_occ + occ_t'(wr_i) - occ_t'(pop_i);
    end
  end

  assign head_o = r_mem[r_rd_ptr];
  assign occ_o  = r_occ;

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a registered-read FIFO into an AXI-Stream master through a 3-deep buffer.
// Optional frame tlast generation is enabled by defining FIFO_AXIS_READER_TLAST_EN.
module fifo_axis_reader
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_BEATS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_r_en_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  m_axis_tlast_o
);

  if (FRAME_BEATS < 1 || FRAME_BEATS > 65535) begin : g_bad_frame_beats
    $error("fifo_axis_reader: FRAME_BEATS must be in 1..65535");
  end

  logic                  r_inflight;
  occ_t                  w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic [2:0]            w_level;
  logic                  w_tvalid;
  logic                  w_pop;

  // Reads are issued only when the buffer can absorb every word already owed,
  // so the issue decision never depends on tready.
  assign w_level     = {1'b0, w_occ} + {2'b00, r_inflight};
  assign fifo_r_en_o = !rst_i && !fifo_empty_i && (w_level <= 3'(BUF_DEPTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_r_en_o;
    end
  end

  assign w_tvalid = (w_occ != '0);
  assign w_pop    = w_tvalid && m_axis_tready_i;

  fifo_reader_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (r_inflight),
    .wr_data_i (fifo_data_i),
    .pop_i     (w_pop),
    .head_o    (w_head),
    .occ_o     (w_occ)
  );

  assign m_axis_tvalid_o = w_tvalid;
  assign m_axis_tdata_o  = w_head;

`ifdef FIFO_AXIS_READER_TLAST_EN
  localparam int                CNT_W     = $clog2(FRAME_BEATS + 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

  logic [CNT_W-1:0] r_beat_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

  assign m_axis_tlast_o = w_tvalid && (r_beat_cnt == LAST_BEAT);
`else
  assign m_axis_tlast_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Randomized self-checking bench for fifo_axis_reader against a word-order
// scoreboard and an owed-word count model of the upstream FIFO.
module tb_fifo_axis_reader;

  localparam int DW = 8;
  localparam int FB = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_r_en_o;
  logic [DW-1:0] m_axis_tdata_o;
  logic          m_axis_tvalid_o;
  logic          tready;
  logic          m_axis_tlast_o;

  always #5 clk = ~clk;

  fifo_axis_reader #(
    .DATA_WIDTH  (DW),
    .FRAME_BEATS (FB)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_data_i     (fifo_data_i),
    .fifo_r_en_o     (fifo_r_en_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tready_i (tready),
    .m_axis_tlast_o  (m_axis_tlast_o)
  );

  int checks   = 0;
  int failures = 0;

  // Upstream FIFO contents and words owed to the stream, in FIFO order.
  int unsigned up_q[$];
  int unsigned exp_q[$];
  int          outstanding = 0;
  logic        rd_flag     = 1'b0;
  logic [DW-1:0] rd_word   = '0;
  int          beat_idx    = 0;
  int          beats       = 0;
  int          last_beats  = 0;
  logic        stall_prev  = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic        prev_last   = 1'b0;
  logic        s_ren, s_tvalid, s_tlast;
  logic [DW-1:0] s_tdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: apply upstream FIFO effects, sample, score, advance.
  task automatic step();
    logic        exp_tvalid;
    logic        exp_last;
    int unsigned dummy;
    if (rd_flag) fifo_data_i = rd_word;
    fifo_empty_i = (up_q.size() == 0);
    #1;
    s_ren    = fifo_r_en_o;
    s_tvalid = m_axis_tvalid_o;
    s_tdata  = m_axis_tdata_o;
    s_tlast  = m_axis_tlast_o;
    if (rst_i) begin
      check("rst_ren", 32'(s_ren), 32'd0);
      exp_q.delete();
      outstanding = 0;
      rd_flag     = 1'b0;
      beat_idx    = 0;
      stall_prev  = 1'b0;
    end else begin
      check("ren", 32'(s_ren), 32'(up_q.size() != 0 && outstanding <= 2));
      // A word is visible once it has spent a cycle in flight.
      exp_tvalid = (outstanding - int'(rd_flag)) > 0;
      check("tvalid", 32'(s_tvalid), 32'(exp_tvalid));
`ifdef FIFO_AXIS_READER_TLAST_EN
      exp_last = s_tvalid && ((beat_idx % FB) == FB - 1);
`else
      exp_last = 1'b0;
`endif
      check("tlast", 32'(s_tlast), 32'(exp_last));
      if (s_tvalid) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'(exp_q.size()), 32'd1);
        else                   check("tdata", 32'(s_tdata), exp_q[0]);
      end
      if (stall_prev) begin
        check("stall_valid", 32'(s_tvalid), 32'd1);
        check("stall_data", 32'(s_tdata), 32'(prev_data));
        check("stall_last", 32'(s_tlast), 32'(prev_last));
      end
      stall_prev = s_tvalid && !tready;
      prev_data  = s_tdata;
      prev_last  = s_tlast;
      if (s_tvalid && tready) begin
        $display("beat %0d data=%02h last=%0b", beat_idx, s_tdata, s_tlast);
        if (exp_q.size() != 0) dummy = exp_q.pop_front();
        beat_idx++;
        beats++;
        outstanding--;
        if (s_tlast) last_beats++;
      end
      rd_flag = s_ren;
      if (s_ren && up_q.size() != 0) begin
        rd_word = DW'(up_q.pop_front());
        exp_q.push_back(32'(rd_word));
        outstanding++;
      end
      check("occ_bound", 32'(outstanding <= 3), 32'd1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    up_q.delete();
  endtask

  task automatic drain(input string tag);
    int k;
    tready = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (up_q.size() == 0 && outstanding == 0) break;
      step();
    end
    check(tag, 32'(up_q.size() == 0 && outstanding == 0), 32'd1);
  endtask

  initial begin
    int first_valid;
    int cnt_ren;
    int cnt_valid;
    int next_word;
    rst_i        = 1'b1;
    tready       = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;

    // Reset with a non-empty FIFO: no read issued, outputs cleared afterwards.
    up_q = '{8'h55, 8'h66};
    step();
    step();
    rst_i = 1'b0;
    up_q.delete();
    step();
    check("post_rst_tvalid", 32'(s_tvalid), 32'd0);
    check("post_rst_tlast", 32'(s_tlast), 32'd0);
    check("post_rst_tdata", 32'(s_tdata), 32'd0);

    // Latency and full throughput.
    for (int i = 1; i <= 16; i++) up_q.push_back(i);
    tready = 1'b1;
    first_valid = -1;
    cnt_valid = 0;
    for (int k = 0; k < 22; k++) begin
      step();
      if (s_tvalid && first_valid < 0) first_valid = k;
      if (s_tvalid && k >= 2 && k <= 17) cnt_valid++;
    end
    check("first_valid_latency", 32'(first_valid), 32'd2);
    check("consecutive_beats", 32'(cnt_valid), 32'd16);
    check("thru_drained", 32'(s_tvalid), 32'd0);

    // Full stall: three reads fill the buffer, then one more per pop.
    do_reset();
    for (int i = 0; i < 8; i++) up_q.push_back(8'h80 + i);
    tready = 1'b0;
    cnt_ren = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      cnt_ren += int'(s_ren);
    end
    check("stall_reads", 32'(cnt_ren), 32'd3);
    check("stall_head", 32'(s_tdata), 32'h80);
    tready = 1'b1;
    step();
    tready = 1'b0;
    cnt_ren = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      cnt_ren += int'(s_ren);
    end
    check("reads_after_pop", 32'(cnt_ren), 32'd1);
    drain("stall_drain");

    // Underflow boundary: a single word.
    do_reset();
    up_q.push_back(8'h3C);
    tready = 1'b1;
    beats = 0;
    cnt_ren = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      cnt_ren += int'(s_ren);
    end
    check("single_reads", 32'(cnt_ren), 32'd1);
    check("single_beats", 32'(beats), 32'd1);
    check("single_idle", 32'(s_tvalid), 32'd0);

    // Reset mid-stream with words buffered and one in flight.
    do_reset();
    for (int i = 0; i < 6; i++) up_q.push_back(8'hC0 + i);
    tready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    up_q.delete();
    cnt_valid = 0;
    cnt_ren = 0;
    tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      cnt_valid += int'(s_tvalid);
      cnt_ren   += int'(s_ren);
    end
    check("mid_rst_valid", 32'(cnt_valid), 32'd0);
    check("mid_rst_ren", 32'(cnt_ren), 32'd0);
    for (int i = 0; i < 4; i++) up_q.push_back(8'hA0 + i);
    beats = 0;
    drain("mid_rst_drain");
    check("mid_rst_beats", 32'(beats), 32'd4);

    // Backpressure: trickled words 0x00..0x3F under random tready.
    do_reset();
    beats = 0;
    next_word = 0;
    for (int k = 0; k < 3000; k++) begin
      if (beats >= 64) break;
      if (next_word < 64 && ($urandom % 4) != 0) begin
        up_q.push_back(next_word);
        next_word++;
      end
      tready = 1'(($urandom % 2) != 0);
      step();
    end
    check("bp_beats", 32'(beats), 32'd64);

    // Frame markers over 12 beats with regular stalls.
    do_reset();
    for (int i = 0; i < 12; i++) up_q.push_back(8'h10 + i);
    beats = 0;
    last_beats = 0;
    for (int k = 0; k < 200; k++) begin
      if (beats >= 12) break;
      tready = 1'((k % 3) != 0);
      step();
    end
    check("frame_beats", 32'(beats), 32'd12);
`ifdef FIFO_AXIS_READER_TLAST_EN
    check("frame_lasts", 32'(last_beats), 32'd3);
`else
    check("frame_lasts", 32'(last_beats), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
